ifetch: RTL
===========

# ifetch

Instruction-fetch and program-counter stage of the SISC datapath. It holds the 16-bit PC, drives the instruction-memory address and latches the fetched 32-bit word into the instruction register (IR). It feeds `opcode`/`mm` to the control FSM and the register/immediate fields to the datapath. It carries out the FSM's `pc_rst`, `pc_write`, `pc_sel`, `br_sel` and `ir_load` commands, including absolute and relative branch target generation.

## Interface
- `PC_W`, 16, PC / instruction-address width
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_f`  in  1  asynchronous, active-low reset
- `ir_load`  in  1  latch `imem_data` into IR this edge
- `pc_write`  in  1  update PC this edge
- `pc_sel`  in  1  0: PC+1, 1: branch target
- `br_sel`  in  1  1: absolute target (imm), 0: relative target (PC+imm)
- `pc_rst`  in  1  synchronous PC clear; highest priority after `rst_f`
- `imem_data`  in  32  instruction word at `imem_addr` (asynchronous-read memory)
- `imem_addr`  out  PC_W  current PC
- `opcode`  out  4  IR[31:28]
- `mm`  out  4  IR[27:24]
- `rd`, `rs`, `rt`  out  4 each  IR[23:20], IR[19:16], IR[15:12]
- `imm`  out  16  IR[15:0]
- `halted`  out  1  HLT latched; PC frozen
- `instr_cnt`, `br_cnt`  out  16 each  present only with `IFETCH_CNT_EN`

## Operation
- State: PC register, IR register, `halted` flag, and the optional counters. All field outputs are direct slices of the IR. The only combinational input-to-output path is PC to `imem_addr`.
- PC next-value priority, evaluated every edge:
  1. `pc_rst`=1: PC←0 and `halted`←0.
  2. Otherwise, if `halted`=1: PC holds.
  3. Otherwise, `pc_write`=1 and `pc_sel`=0: PC←PC+1.
  4. Otherwise, `pc_write`=1 and `pc_sel`=1: PC←branch target.
  5. Otherwise: PC holds.
- Branch target:
  - `br_sel`=1: `imm[PC_W-1:0]`.
  - `br_sel`=0: PC + sign-extended `imm`, modulo 2^PC_W.
  - PC at this point already points at the instruction after the branch.
- IR: `ir_load`=1 → IR←`imem_data`. The load is permitted while `halted`=1, and the PC still holds.
- Halt: `halted`←1 on any edge where the IR opcode equals 4'hF and `pc_rst`=0. It stays set until `pc_rst` or `rst_f`.
- PC arithmetic wraps: 16'hFFFF+1 = 0. Relative target 0x0002 + 0xFFFC = 0xFFFE.
- Simultaneous `ir_load` and `pc_write` (the fetch cycle): IR captures the word at the old PC; PC advances on the same edge.

## Timing
- `rst_f`=0 asynchronously forces: PC=0, IR=0 (so `opcode`=NOOP and all fields 0), `halted`=0, counters=0. All outputs read 0 during reset.
- The first rising edge after `rst_f` deasserts performs normal updates.
- Latency:
  - `imem_addr` follows PC combinationally.
  - Field outputs change one edge after `ir_load`.
  - A branch takes effect on the edge where `pc_write`=1, so the new `imem_addr` is visible immediately afterwards.
- Inputs need no handshake; the FSM guarantees one command set per cycle. Illegal combinations resolve by the priority above.
- Reset asserted mid-branch aborts the update; PC=0 on release.

## Configuration
- `IFETCH_CNT_EN` defined:
  - `instr_cnt` increments on every edge with `ir_load`=1.
  - `br_cnt` increments on every edge where a branch target is actually written: `pc_write`=1, `pc_sel`=1, not halted, not `pc_rst`.
  - Both counters wrap at 2^16, clear on `rst_f` and `pc_rst`, and hold while halted except `instr_cnt` on `ir_load`.
- Undefined: counters and both ports are absent; all other behaviour is identical.

## Test plan
- Reset then sequential fetch: `rst_f` low, release. Memory holds 0x10000000, 0x20000000, 0x30000000 at 0..2. Three cycles of `ir_load`=`pc_write`=1, `pc_sel`=0 → `opcode` 1, 2, 3 on successive edges; `imem_addr` 1, 2, 3.
- Absolute branch: IR.imm=0x0040, `br_sel`=1, `pc_sel`=1, `pc_write`=1 → PC=0x0040.
- Relative branch with negative offset and wrap:
  - PC=0x0005, imm=0xFFFD, `br_sel`=0 → PC=0x0002.
  - PC=0x0002, imm=0xFFFC → PC=0xFFFE.
- Halt:
  - Load 0xF0000000 → `halted`=1; further `pc_write` pulses leave PC unchanged.
  - `pc_rst`=1 → PC=0, `halted`=0.
- Priority and async reset:
  - `pc_rst`=1 together with `pc_write`=1, `pc_sel`=1 → PC=0.
  - Drop `rst_f` between clock edges → PC, IR and all outputs go to 0 without a clock.
- With `IFETCH_CNT_EN`: 4 fetches + 1 taken branch + 1 suppressed branch while halted → `instr_cnt`=4, `br_cnt`=1.

Source files
------------

// File: rtl/ifetch.sv
//------------------------------------------------------------------------------
// ifetch
//   Instruction-fetch / program-counter stage of the SISC datapath.
//   Holds the PC, addresses instruction memory, latches the fetched word into
//   the instruction register (IR) and decodes IR fields for control/datapath.
//   Executes pc_rst / pc_write / pc_sel / br_sel / ir_load commands, including
//   absolute (imm) and relative (PC + sext(imm)) branch targets.
//
// Ports
//   clk        in   system clock, rising-edge active
//   rst_f      in   asynchronous active-low reset
//   ir_load    in   latch imem_data into IR
//   pc_write   in   update PC this edge
//   pc_sel     in   0: PC+1, 1: branch target
//   br_sel     in   1: absolute target, 0: PC-relative target
//   pc_rst     in   synchronous PC clear (also clears halt and counters)
//   imem_data  in   instruction word at imem_addr (async-read memory)
//   imem_addr  out  current PC
//   opcode/mm/rd/rs/rt/imm  out  IR field slices
//   halted     out  HLT seen; PC frozen until pc_rst / rst_f
//   instr_cnt, br_cnt  out  fetch / taken-branch counters (IFETCH_CNT_EN only)
//
// Configuration macro: IFETCH_CNT_EN adds instr_cnt and br_cnt.
// PC_W may be 1..32; wider-than-16 targets use the sign-extended immediate.
//
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ifetch #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            ir_load,
  input  logic            pc_write,
  input  logic            pc_sel,
  input  logic            br_sel,
  input  logic            pc_rst,
  input  logic [31:0]     imem_data,
  output logic [PC_W-1:0] imem_addr,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [15:0]     imm,
  output logic            halted
`ifdef IFETCH_CNT_EN
  ,
  output logic [15:0]     instr_cnt,
  output logic [15:0]     br_cnt
`endif
);

  localparam logic [3:0]      OP_HLT = 4'hF;
  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            halt_q;
  logic [31:0]     imm_sx;
  logic [PC_W-1:0] br_target;

  // Immediate sign-extended to 32 bits; the low PC_W bits feed both target
  // forms, which for PC_W<=16 is exactly imm[PC_W-1:0].
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  // The PC already points past the branch when the relative add happens.
  always_comb begin
    br_target = imm_sx[PC_W-1:0];
    if (!br_sel) begin
      br_target = pc + imm_sx[PC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc <= '0;
    end else if (pc_rst) begin
      pc <= '0;
    end else if (!halt_q && pc_write) begin
      pc <= pc_sel ? br_target : (pc + PC_ONE);
    end
  end

  // IR loads are allowed while halted; pc_rst does not touch the IR.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ir <= '0;
    end else if (ir_load) begin
      ir <= imem_data;
    end
  end

  // Halt is detected from the registered opcode, so it takes effect one edge
  // after the HLT word lands in the IR.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      halt_q <= 1'b0;
    end else if (pc_rst) begin
      halt_q <= 1'b0;
    end else if (ir[31:28] == OP_HLT) begin
      halt_q <= 1'b1;
    end
  end

`ifdef IFETCH_CNT_EN
  logic        br_taken;
  logic [15:0] instr_q;
  logic [15:0] br_q;

  assign br_taken = pc_write & pc_sel & ~halt_q & ~pc_rst;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      instr_q <= '0;
      br_q    <= '0;
    end else if (pc_rst) begin
      instr_q <= '0;
      br_q    <= '0;
    end else begin
      if (ir_load) begin
        instr_q <= instr_q + 16'd1;
      end
      if (br_taken) begin
        br_q <= br_q + 16'd1;
      end
    end
  end

  assign instr_cnt = instr_q;
  assign br_cnt    = br_q;
`endif

  assign imem_addr = pc;
  assign opcode    = ir[31:28];
  assign mm        = ir[27:24];
  assign rd        = ir[23:20];
  assign rs        = ir[19:16];
  assign rt        = ir[15:12];
  assign imm       = ir[15:0];
  assign halted    = halt_q;

endmodule

`default_nettype wire
